// File: rtl/mmio_ctrl_pkg.sv
// MMIO controller shared definitions: opcodes, address map,
// writeback-select codes and TX state encoding.
package mmio_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;

  localparam logic [31:0] MMIO_CTRL    = 32'h8000_0000;
  localparam logic [31:0] MMIO_RX      = 32'h8000_0004;
  localparam logic [31:0] MMIO_TX      = 32'h8000_0008;
  localparam logic [31:0] MMIO_CYC     = 32'h8000_0010;
  localparam logic [31:0] MMIO_INST    = 32'h8000_0014;
  localparam logic [31:0] MMIO_CNT_RST = 32'h8000_0018;
  localparam logic [31:0] MMIO_BR      = 32'h8000_001C;
  localparam logic [31:0] MMIO_CORR_BR = 32'h8000_0020;

  typedef enum logic [1:0] {
    WB_MEM  = 2'd0,
    WB_ALU  = 2'd1,
    WB_PC4  = 2'd2,
    WB_MMIO = 2'd3
  } wb_sel_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_e;

  function automatic logic [31:0] ctrl_word(
    input logic ovr,
    input logic rxv,
    input logic free
  );
    return {29'b0, ovr, rxv, free};
  endfunction

endpackage

// File: rtl/mmio_if.sv
// M-stage MMIO bus plus UART handshakes, as seen by the
// controller (slave) and the core/UART side (master).
interface mmio_if #(
  parameter int W_SIZE = 32
);
  logic              mem_valid_m;
  logic [6:0]        opcode_m;
  logic [W_SIZE-1:0] addr;
  logic [W_SIZE-1:0] wdata;
  logic              inst_retire;
  logic              br_resolved;
  logic              br_correct;
  logic [7:0]        uart_rx_data;
  logic              uart_rx_valid;
  logic              uart_rx_ready;
  logic [7:0]        uart_tx_data;
  logic              uart_tx_valid;
  logic              uart_tx_ready;
  logic [W_SIZE-1:0] rdata_w;

  modport master (
    output mem_valid_m, opcode_m, addr, wdata,
    output inst_retire, br_resolved, br_correct,
    output uart_rx_data, uart_rx_valid, uart_tx_ready,
    input  uart_rx_ready, uart_tx_data, uart_tx_valid,
    input  rdata_w
  );

  modport slave (
    input  mem_valid_m, opcode_m, addr, wdata,
    input  inst_retire, br_resolved, br_correct,
    input  uart_rx_data, uart_rx_valid, uart_tx_ready,
    output uart_rx_ready, uart_tx_data, uart_tx_valid,
    output rdata_w
  );

endinterface

// File: rtl/mmio_ctrl_counter.sv
// Wrapping performance counter; clear beats increment.
module mmio_counter #(
  parameter int W_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [W_SIZE-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + W_SIZE'(1);
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-stage MMIO controller: UART TX/RX handshakes,
// performance counters and registered read data for WB.
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int W_SIZE = 32
) (
  input logic   clk,
  input logic   rst,
  mmio_if.slave bus
);

  logic ld, st;
  logic hit_ctrl, hit_rx, hit_tx, hit_cyc;
  logic hit_inst, hit_cnt_rst, hit_br, hit_corr;
  logic cnt_clr;

  tx_state_e   tx_state;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        tx_overrun;

  logic [W_SIZE-1:0] cyc_q, inst_q, br_q, corr_q;
  logic [W_SIZE-1:0] rd_next, rdata_q;
  logic              unused_wdata;

  assign ld = bus.mem_valid_m && (bus.opcode_m == OP_LOAD);
  assign st = bus.mem_valid_m && (bus.opcode_m == OP_STORE);

  assign hit_ctrl    = bus.addr == W_SIZE'(MMIO_CTRL);
  assign hit_rx      = bus.addr == W_SIZE'(MMIO_RX);
  assign hit_tx      = bus.addr == W_SIZE'(MMIO_TX);
  assign hit_cyc     = bus.addr == W_SIZE'(MMIO_CYC);
  assign hit_inst    = bus.addr == W_SIZE'(MMIO_INST);
  assign hit_cnt_rst = bus.addr == W_SIZE'(MMIO_CNT_RST);
  assign hit_br      = bus.addr == W_SIZE'(MMIO_BR);
  assign hit_corr    = bus.addr == W_SIZE'(MMIO_CORR_BR);

  assign cnt_clr      = st && hit_cnt_rst;
  assign unused_wdata = ^bus.wdata[W_SIZE-1:8];

  assign bus.uart_rx_ready = ld && hit_rx && bus.uart_rx_valid;
  assign bus.uart_tx_valid = tx_valid_q;
  assign bus.uart_tx_data  = tx_data_q;
  assign bus.rdata_w       = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (st && hit_tx) begin
            tx_state   <= TX_PEND;
            tx_valid_q <= 1'b1;
            tx_data_q  <= bus.wdata[7:0];
          end
        end
        TX_PEND: begin
          if (tx_valid_q && bus.uart_tx_ready) begin
            tx_state   <= TX_IDLE;
            tx_valid_q <= 1'b0;
          end
        end
        default: begin
          tx_state   <= TX_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // a store landing while a byte is pending sets the flag over a CTRL-read clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_overrun <= 1'b0;
    end else if (st && hit_tx && tx_state == TX_PEND) begin
      tx_overrun <= 1'b1;
    end else if (ld && hit_ctrl) begin
      tx_overrun <= 1'b0;
    end
  end

  mmio_counter #(.W_SIZE(W_SIZE)) u_cyc (
    .clk(clk), .rst(rst), .clr(cnt_clr),
    .inc(1'b1), .q(cyc_q)
  );

  mmio_counter #(.W_SIZE(W_SIZE)) u_inst (
    .clk(clk), .rst(rst), .clr(cnt_clr),
    .inc(bus.inst_retire), .q(inst_q)
  );

  mmio_counter #(.W_SIZE(W_SIZE)) u_br (
    .clk(clk), .rst(rst), .clr(cnt_clr),
    .inc(bus.br_resolved), .q(br_q)
  );

  mmio_counter #(.W_SIZE(W_SIZE)) u_corr (
    .clk(clk), .rst(rst), .clr(cnt_clr),
    .inc(bus.br_resolved && bus.br_correct),
    .q(corr_q)
  );

  always_comb begin
    rd_next = '0;
    if (ld) begin
      unique case (1'b1)
        hit_ctrl: rd_next = W_SIZE'(ctrl_word(
                    tx_overrun, bus.uart_rx_valid,
                    tx_state == TX_IDLE));
        hit_rx:   rd_next = bus.uart_rx_valid
                    ? W_SIZE'(bus.uart_rx_data) : '0;
        hit_cyc:  rd_next = cyc_q;
        hit_inst: rd_next = inst_q;
        hit_br:   rd_next = br_q;
        hit_corr: rd_next = corr_q;
        default:  rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rd_next;
    end
  end

endmodule
